// File: rtl/bcd_to_binary_converter.sv
// Sequential 10-digit packed-BCD to 32-bit binary converter (reverse double-dabble, one bit per clock).
// Optional macro BCD_CHECK_EN: reject inputs with a digit > 9 in one cycle and flag invalid_o.
module bcd_to_binary_converter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [39:0] BCD_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] binary_o,
    output logic        overflow_o,
    output logic        invalid_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OP   = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [39:0] bcd_reg;
    logic [31:0] bin_reg;
    logic [4:0]  bit_cnt;
    logic [71:0] shifted;
    logic [39:0] bcd_next;
    logic [31:0] bin_next;
    logic        digit_bad;

    // One iteration: shift the combined register right, then pull every digit >= 8 back by 3.
    always_comb begin
        shifted  = {bcd_reg, bin_reg} >> 1;
        bin_next = shifted[31:0];
        bcd_next = shifted[71:32];
        for (int k = 0; k < 10; k++) begin
            if (shifted[32 + 4*k + 3]) begin
                bcd_next[4*k +: 4] = shifted[32 + 4*k +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_CHECK_EN
    always_comb begin
        digit_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (BCD_i[4*k +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end
`else
    assign digit_bad = 1'b0;
`endif

    assign ready_o = (state == IDLE);
    assign done_o  = (state == DONE);

    // Results are loaded on the edge that enters DONE so they are valid while done_o is high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            bcd_reg    <= '0;
            bin_reg    <= '0;
            bit_cnt    <= '0;
            binary_o   <= '0;
            overflow_o <= 1'b0;
            invalid_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        bcd_reg <= BCD_i;
                        bin_reg <= '0;
                        bit_cnt <= 5'd31;
                        if (digit_bad) begin
                            state      <= DONE;
                            binary_o   <= '0;
                            overflow_o <= 1'b0;
                            invalid_o  <= 1'b1;
                        end else begin
                            state <= OP;
                        end
                    end
                end
                OP: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    bit_cnt <= bit_cnt - 5'd1;
                    if (bit_cnt == 5'd0) begin
                        state      <= DONE;
                        binary_o   <= bin_next;
                        overflow_o <= (bcd_next != 40'd0);
                        invalid_o  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Self-checking bench for bcd_to_binary_converter: directed vectors, random digits against an
// arithmetic decimal model, held-start, mid-conversion reset and the optional digit check.
module tb_bcd_to_binary_converter;

    logic        clk_i;
    logic        reset_i;
    logic        start_i;
    logic [39:0] BCD_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] binary_o;
    logic        overflow_o;
    logic        invalid_o;

    int assertCount = 0;
    int failCount   = 0;

    bcd_to_binary_converter dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .BCD_i      (BCD_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .binary_o   (binary_o),
        .overflow_o (overflow_o),
        .invalid_o  (invalid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [39:0] bcd;
        logic [31:0] bin;
        logic        ovf;
    } vector_t;

    // Decimal value of the packed digits, computed with plain arithmetic.
    function automatic logic [63:0] decimalValue(input logic [39:0] b);
        logic [63:0] v;
        v = 64'd0;
        for (int k = 9; k >= 0; k--) begin
            v = v * 64'd10 + {60'd0, b[4*k +: 4]};
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Pulse start with a value and wait for done_o; latency counts the accepting edge as 1.
    task automatic applyStimulus(input logic [39:0] bcd, output int latency);
        @(negedge clk_i);
        BCD_i   = bcd;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        BCD_i   = {$urandom, $urandom} ;
        latency = 1;
        while (!done_o && latency < 100) begin
            @(posedge clk_i);
            #1;
            latency++;
        end
        if (!done_o) begin
            checkOutput("done_timeout", 64'(latency), 64'd33);
        end
    endtask

    task automatic runVector(input string name, input logic [39:0] bcd,
                             input logic [31:0] expBin, input logic expOvf);
        int lat;
        applyStimulus(bcd, lat);
        checkOutput({name, "_latency"}, 64'(lat), 64'd33);
        checkOutput({name, "_binary"}, 64'(binary_o), 64'(expBin));
        checkOutput({name, "_overflow"}, 64'(overflow_o), 64'(expOvf));
        checkOutput({name, "_invalid"}, 64'(invalid_o), 64'd0);
        @(posedge clk_i);
        #1;
        checkOutput({name, "_done_width"}, 64'(done_o), 64'd0);
        checkOutput({name, "_ready_after"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        vector_t vectors[6];
        int          lat;
        logic [39:0] rbcd;
        logic [63:0] val;
        int          doneCycles[$];
        logic [31:0] doneBins[$];
        logic [39:0] firstVal;
        logic [39:0] secondVal;
        int          cyc;
        int          sawDone;

        vectors[0] = '{40'h00_0001_2345, 32'h0000_3039, 1'b0};
        vectors[1] = '{40'h42_9496_7295, 32'hFFFF_FFFF, 1'b0};
        vectors[2] = '{40'h42_9496_7296, 32'h0000_0000, 1'b1};
        vectors[3] = '{40'h99_9999_9999, 32'h540B_E3FF, 1'b1};
        vectors[4] = '{40'h00_0000_0000, 32'h0000_0000, 1'b0};
        vectors[5] = '{40'h00_0000_0100, 32'h0000_0064, 1'b0};

        reset_i = 1'b1;
        start_i = 1'b0;
        BCD_i   = 40'd0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        checkOutput("reset_ready", 64'(ready_o), 64'd1);
        checkOutput("reset_done", 64'(done_o), 64'd0);
        checkOutput("reset_binary", 64'(binary_o), 64'd0);
        checkOutput("reset_overflow", 64'(overflow_o), 64'd0);
        checkOutput("reset_invalid", 64'(invalid_o), 64'd0);

        for (int i = 0; i < 6; i++) begin
            runVector($sformatf("vec%0d", i), vectors[i].bcd, vectors[i].bin, vectors[i].ovf);
        end

        // Random valid digits checked against the decimal model.
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 10; k++) begin
                rbcd[4*k +: 4] = 4'($urandom_range(9, 0));
            end
            val = decimalValue(rbcd);
            runVector($sformatf("rand%0d", i), rbcd, val[31:0], val > 64'h0000_0000_FFFF_FFFF);
        end

        // Start held across two conversions with BCD_i changing mid-conversion.
        firstVal  = 40'h00_0012_3456;
        secondVal = 40'h00_0000_0789;
        @(negedge clk_i);
        BCD_i   = firstVal;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        cyc = 1;
        checkOutput("held_ready_low", 64'(ready_o), 64'd0);
        while (cyc < 80) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (cyc == 10) BCD_i = secondVal;
            if (done_o) begin
                doneCycles.push_back(cyc);
                doneBins.push_back(binary_o);
                if (doneCycles.size() == 2) start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        checkOutput("held_done_count", 64'(doneCycles.size()), 64'd2);
        if (doneCycles.size() == 2) begin
            val = decimalValue(firstVal);
            checkOutput("held_first_cycle", 64'(doneCycles[0]), 64'd33);
            checkOutput("held_first_binary", 64'(doneBins[0]), 64'(val[31:0]));
            val = decimalValue(secondVal);
            checkOutput("held_spacing", 64'(doneCycles[1] - doneCycles[0]), 64'd34);
            checkOutput("held_second_binary", 64'(doneBins[1]), 64'(val[31:0]));
        end

        // Reset asserted partway through OP aborts the conversion.
        @(negedge clk_i);
        BCD_i   = 40'h00_0000_5555;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (15) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        checkOutput("midreset_ready", 64'(ready_o), 64'd1);
        checkOutput("midreset_done", 64'(done_o), 64'd0);
        checkOutput("midreset_binary", 64'(binary_o), 64'd0);
        checkOutput("midreset_overflow", 64'(overflow_o), 64'd0);
        sawDone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) sawDone++;
        end
        checkOutput("midreset_no_done", 64'(sawDone), 64'd0);
        runVector("after_reset", 40'h00_0000_0100, 32'h0000_0064, 1'b0);

        // Digit > 9: rejected immediately with the check, converted normally without it.
        applyStimulus(40'h00_0000_00A1, lat);
`ifdef BCD_CHECK_EN
        checkOutput("invalid_latency", 64'(lat), 64'd1);
        checkOutput("invalid_flag", 64'(invalid_o), 64'd1);
        checkOutput("invalid_binary", 64'(binary_o), 64'd0);
        checkOutput("invalid_overflow", 64'(overflow_o), 64'd0);
`else
        checkOutput("invalid_latency", 64'(lat), 64'd33);
        checkOutput("invalid_flag", 64'(invalid_o), 64'd0);
`endif
        @(posedge clk_i);
        #1;
        checkOutput("invalid_done_width", 64'(done_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_converter.md
# bcd_to_binary_converter

Sequential 10-digit packed-BCD to 32-bit unsigned binary converter using reverse double-dabble (shift-right / subtract-3), one bit per clock. It is the inverse of the team's binary-to-BCD converter. It sits between decimal-entry front ends (keypad or UART digit buffers) and binary arithmetic datapaths. It uses the same start/ready/done handshake, so the two converters can be chained for round-trip checks.

## Interface
- No parameters; widths fixed at 40-bit BCD in, 32-bit binary out.
- clk_i  input  1  system clock, all logic on rising edge
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  request conversion; sampled only while ready_o=1
- BCD_i  input  40  10 packed BCD digits, digit k at [4k+3:4k], k=0 least significant
- ready_o  output  1  high in IDLE only
- done_o  output  1  one-cycle pulse when result valid
- binary_o  output  32  converted value, registered, held until next accepted start
- overflow_o  output  1  decimal value > 4294967295; registered with binary_o
- invalid_o  output  1  some input digit > 9 (only with BCD_CHECK_EN); registered with binary_o

## Operation
- Reset (synchronous, reset_i high at clock edge) forces the following, regardless of state:
  - state=IDLE, binary_o=0, overflow_o=0, invalid_o=0, done_o=0, ready_o=1 after the edge.
- FSM states IDLE, OP, DONE; any unused encoding goes to IDLE.
- IDLE:
  - ready_o=1.
  - On start_i=1: load bcd_reg←BCD_i, bin_reg←0, bit_cnt←31, go to OP.
  - With the check enabled and an invalid digit present: go straight to DONE (see Configuration).
- OP, each cycle:
  - {bcd_reg,bin_reg} (72 bits) shifted right 1.
  - Then every 4-bit digit of the shifted bcd_reg with value ≥8 has 3 subtracted (mod-16 nibble arithmetic, no inter-digit borrow).
  - bit_cnt decrements; after the cycle with bit_cnt=0, go to DONE.
- DONE:
  - done_o=1.
  - binary_o←bin_reg; overflow_o←(bcd_reg≠0), i.e. residual after 32 shifts.
  - Next state IDLE.
- With overflow, binary_o = decimal value mod 2^32.
- start_i is ignored in OP and DONE; BCD_i is sampled only on the accepting edge and may change afterwards.
- Leading zero digits need no special handling; all 32 iterations always run.

## Timing
- Start accepted at edge E0 → OP for 32 cycles (edges E1..E32) → DONE during cycle after E32 → IDLE after E33.
- done_o high exactly one cycle. binary_o, overflow_o and invalid_o are updated on the edge that enters DONE, so they are valid while done_o=1 and stable until the next accepted start's completion.
- Latency start-edge to done_o: 33 cycles. Throughput: one conversion per 34 cycles; a start held high re-triggers at the first IDLE cycle after DONE.
- ready_o=0 from the cycle after acceptance through DONE.
- Reset mid-OP aborts; no done_o pulse; outputs cleared.

## Configuration
- Macro BCD_CHECK_EN.
- Defined:
  - On acceptance, if any digit of BCD_i > 9, skip OP and enter DONE next cycle (latency 1).
  - In that case: invalid_o=1, binary_o=0, overflow_o=0.
  - For valid input: invalid_o=0 and operation as normal.
- Undefined:
  - No digit check; invalid_o tied 0.
  - Invalid digits are converted by the same algorithm with an unspecified result; latency is always 33.

## Test plan
- Reset then BCD_i=40'h00_0001_2345, start pulse → done_o at cycle 33, binary_o=32'h0000_3039, overflow_o=0, invalid_o=0.
- BCD_i=40'h42_9496_7295 → binary_o=32'hFFFF_FFFF, overflow_o=0; then 40'h42_9496_7296 → binary_o=0, overflow_o=1.
- BCD_i=40'h99_9999_9999 → binary_o=32'h540B_E3FF, overflow_o=1; BCD_i=0 → binary_o=0, overflow_o=0.
- start_i held high across two conversions with a BCD_i change at cycle 10 → first result uses the originally sampled value; second accepted at first IDLE cycle; each done_o exactly 1 cycle, 34 cycles apart.
- reset_i asserted at OP cycle 15 → IDLE next cycle, ready_o=1, no done_o, binary_o=0; subsequent conversion of 40'h00_0000_0100 → 32'h64.
- With BCD_CHECK_EN: BCD_i=40'h00_0000_00A1 → done_o the cycle after acceptance, invalid_o=1, binary_o=0; without the macro → latency 33, invalid_o=0.
